// File: rtl/requant_pkg.sv
// Shared constants and helpers for the multi-lane requantiser.
// Helpers operate on a fixed maximum width so any lane width up to 64 bits fits.
package requant_pkg;

    localparam int cMAX_W = 64;

    typedef enum logic {
        MODE_LIN = 1'b0,
        MODE_LOG = 1'b1
    } mode_e;

    localparam string cMODE_LIN = "lin";
    localparam string cMODE_LOG = "log";

    function automatic int mant_w(input int out_w, input int exp_w);
        return out_w - exp_w;
    endfunction

    function automatic int shift_w(input int in_w);
        return $clog2(in_w);
    endfunction

    function automatic int lead_one_idx(input logic [cMAX_W-1:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < cMAX_W; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

    // Clamp an unsigned value to the largest w-bit code.
    function automatic logic [cMAX_W-1:0] sat_u(input logic [cMAX_W-1:0] v, input int w);
        logic [cMAX_W-1:0] lim;
        lim = (w >= cMAX_W) ? '1 : ((cMAX_W'(1) << w) - cMAX_W'(1));
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/requant_lane.sv
// One lane of the requantiser: stage-1 pre-processing register and stage-2 result register.
// Load enables come from the shared handshake control in the top.
module requant_lane
    import requant_pkg::*;
#(
    parameter int    pIN_W  = 16,
    parameter int    pOUT_W = 8,
    parameter int    pEXP_W = 4,
    parameter int    pSH_W  = 4,
    parameter mode_e pMODE  = MODE_LIN
) (
    input  logic              iclk,
    input  logic              irst_n,
    input  logic              ien1,
    input  logic              ien2,
    input  logic [pIN_W-1:0]  iv,
    input  logic [pSH_W-1:0]  ishift1,
    input  logic [pSH_W-1:0]  ishift2,
    output logic [pOUT_W-1:0] oq,
    output logic              osat
);

    logic [pIN_W:0]    s1_q;
    logic [pSH_W-1:0]  p1_q;
    logic [pIN_W:0]    s1_d;
    logic [pSH_W-1:0]  p1_d;
    logic [pOUT_W-1:0] q_d;
    logic              sat_d;

    if (pMODE == MODE_LIN) begin : g_lin
        logic [pIN_W:0]    rnd;
        logic [cMAX_W-1:0] r;
        logic              unused_lin;

        // (1 << sh) >> 1 yields the half-LSB rounding term, and zero when sh is zero.
        always_comb begin
            rnd   = ((pIN_W+1)'(1) << ishift1) >> 1;
            s1_d  = {1'b0, iv} + rnd;
            p1_d  = '0;
            r     = cMAX_W'(s1_q >> ishift2);
            q_d   = pOUT_W'(sat_u(r, pOUT_W));
            sat_d = (r >> pOUT_W) != '0;
        end
        assign unused_lin = ^p1_q;
    end else begin : g_log
        localparam int M = mant_w(pOUT_W, pEXP_W);
        logic [cMAX_W-1:0] v;
        int                seg;
        logic              unused_log;

        always_comb begin
            s1_d  = {1'b0, iv};
            p1_d  = pSH_W'(lead_one_idx(cMAX_W'(iv)));
            v     = cMAX_W'(s1_q);
            seg   = int'(p1_q) - M + 1;
            sat_d = 1'b0;
            if (v < (cMAX_W'(1) << M)) begin
                q_d = pOUT_W'(v);
            end else begin
                q_d = {pEXP_W'(seg), M'(v >> (int'(p1_q) - M))};
            end
        end
        assign unused_log = ^{ishift1, ishift2};
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            s1_q <= '0;
            p1_q <= '0;
            oq   <= '0;
            osat <= 1'b0;
        end else begin
            if (ien1) begin
                s1_q <= s1_d;
                p1_q <= p1_d;
            end
            if (ien2) begin
                oq   <= q_d;
                osat <= sat_d;
            end
        end
    end

endmodule

// File: rtl/requant_pipe.sv
// Multi-lane, two-stage valid/ready requantiser: linear shift/round/saturate or log compression.
// Owns the handshake chain, the per-beat sideband pipeline and the sticky saturation flag.
module requant_pipe
    import requant_pkg::*;
#(
    parameter int    pIN_W  = 16,
    parameter int    pOUT_W = 8,
    parameter int    pCH    = 4,
    parameter string pMODE  = "lin",
    parameter int    pEXP_W = 4
) (
    input  logic                      iclk,
    input  logic                      irst_n,
    input  logic                      ivalid,
    output logic                      oready,
    input  logic [pCH*pIN_W-1:0]      idata,
    input  logic [$clog2(pIN_W)-1:0]  ishift,
    input  logic                      ilast,
    output logic                      ovalid,
    input  logic                      iready,
    output logic [pCH*pOUT_W-1:0]     odata,
    output logic                      olast,
    output logic                      osat,
    input  logic                      iclr_sat
);

    localparam int    cSH_W = shift_w(pIN_W);
    localparam int    cM    = mant_w(pOUT_W, pEXP_W);
    localparam mode_e cMODE = (pMODE == cMODE_LOG) ? MODE_LOG : MODE_LIN;

    if (pMODE != cMODE_LIN && pMODE != cMODE_LOG) begin : g_bad_mode
        $error("requant_pipe: pMODE must be lin or log");
    end
    if (pMODE == cMODE_LOG && ((pIN_W - cM) > (2**pEXP_W - 1) || cM < 1)) begin : g_bad_log
        $error("requant_pipe: segment field too narrow for pIN_W/pOUT_W/pEXP_W");
    end

    logic             v1_q, v2_q;
    logic             last1_q, last2_q;
    logic [cSH_W-1:0] sh1_q;
    logic             adv1, adv2, acc;
    logic [pCH-1:0]   lane_sat;

    assign adv2   = !v2_q || iready;
    assign adv1   = !v1_q || adv2;
    assign oready = adv1;
    assign acc    = ivalid && adv1;
    assign ovalid = v2_q;
    assign olast  = last2_q;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            last1_q <= 1'b0;
            last2_q <= 1'b0;
            sh1_q   <= '0;
            osat    <= 1'b0;
        end else begin
            if (adv1) begin
                v1_q <= acc;
                if (acc) begin
                    sh1_q   <= ishift;
                    last1_q <= ilast;
                end
            end
            if (adv2) begin
                v2_q <= v1_q;
                if (v1_q) last2_q <= last1_q;
            end
            // Only a consumed beat may flag saturation; set beats a same-cycle clear.
            if (v2_q && iready && (|lane_sat)) begin
                osat <= 1'b1;
            end else if (iclr_sat) begin
                osat <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < pCH; k++) begin : g_lane
        requant_lane #(
            .pIN_W  (pIN_W),
            .pOUT_W (pOUT_W),
            .pEXP_W (pEXP_W),
            .pSH_W  (cSH_W),
            .pMODE  (cMODE)
        ) u_lane (
            .iclk    (iclk),
            .irst_n  (irst_n),
            .ien1    (acc),
            .ien2    (adv2 && v1_q),
            .iv      (idata[k*pIN_W +: pIN_W]),
            .ishift1 (ishift),
            .ishift2 (sh1_q),
            .oq      (odata[k*pOUT_W +: pOUT_W]),
            .osat    (lane_sat[k])
        );
    end

endmodule

// File: tb/tb_requant_pipe.sv
// Bench for requant_pipe: a lin and a log instance share stimulus; a scoreboard of
// arithmetic reference results checks every presented output beat and the sticky flag.
module tb_requant_pipe;

    logic        iclk = 1'b0;
    logic        irst_n, ivalid, ilast, iready, iclr_sat;
    logic [63:0] idata;
    logic [3:0]  ishift;
    logic        oready_l, ovalid_l, olast_l, osat_l;
    logic [31:0] odata_l;
    logic        oready_g, ovalid_g, olast_g, osat_g;
    logic [31:0] odata_g;

    always #5 iclk = ~iclk;

    requant_pipe #(.pMODE("lin")) u_lin (
        .iclk(iclk), .irst_n(irst_n), .ivalid(ivalid), .oready(oready_l),
        .idata(idata), .ishift(ishift), .ilast(ilast), .ovalid(ovalid_l),
        .iready(iready), .odata(odata_l), .olast(olast_l), .osat(osat_l),
        .iclr_sat(iclr_sat));

    requant_pipe #(.pMODE("log")) u_log (
        .iclk(iclk), .irst_n(irst_n), .ivalid(ivalid), .oready(oready_g),
        .idata(idata), .ishift(ishift), .ilast(ilast), .ovalid(ovalid_g),
        .iready(iready), .odata(odata_g), .olast(olast_g), .osat(osat_g),
        .iclr_sat(iclr_sat));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] d;
        logic        last;
        logic        sat;
    } exp_t;

    exp_t q_lin[$];
    exp_t q_log[$];

    function automatic exp_t model_lin(input logic [63:0] d, input int sh, input logic last);
        exp_t e;
        e.d = '0; e.last = last; e.sat = 1'b0;
        for (int k = 0; k < 4; k++) begin
            int v, r;
            v = int'({16'h0, d[k*16 +: 16]});
            r = (v + ((sh > 0) ? (1 << (sh - 1)) : 0)) >> sh;
            if (r > 255) begin
                e.sat = 1'b1;
                r = 255;
            end
            e.d[k*8 +: 8] = 8'(r);
        end
        return e;
    endfunction

    function automatic exp_t model_log(input logic [63:0] d, input logic last);
        exp_t e;
        e.d = '0; e.last = last; e.sat = 1'b0;
        for (int k = 0; k < 4; k++) begin
            int v, p, t, o;
            v = int'({16'h0, d[k*16 +: 16]});
            if (v < 16) begin
                o = v;
            end else begin
                p = 0;
                t = v;
                while (t > 1) begin
                    t = t >> 1;
                    p++;
                end
                o = ((p - 3) << 4) | ((v >> (p - 4)) & 15);
            end
            e.d[k*8 +: 8] = 8'(o);
        end
        return e;
    endfunction

    int   cyc = 0;
    int   last_acc_cyc = 0;
    logic exp_sat = 1'b0;
    logic bp_on = 1'b0;
    logic bp_drop = 1'b0;
    int   n_cons = 0;
    int   n_last = 0;

    always @(posedge iclk) cyc++;

    always @(negedge iclk) begin
        logic cons_sat;
        cons_sat = 1'b0;
        if (!irst_n) begin
            q_lin.delete();
            q_log.delete();
            exp_sat = 1'b0;
            chk("rst_ovalid", ovalid_l, 1'b0);
        end else begin
            chk("lin_osat", osat_l, exp_sat);
            chk("log_osat", osat_g, 1'b0);
            if (bp_on && !oready_l) bp_drop = 1'b1;
            if (ovalid_l) begin
                if (q_lin.size() == 0) begin
                    chk("lin_extra_beat", ovalid_l, 1'b0);
                end else begin
                    chk("lin_data", odata_l, q_lin[0].d);
                    chk("lin_last", olast_l, q_lin[0].last);
                    if (iready) begin
                        cons_sat = q_lin[0].sat;
                        n_cons++;
                        if (q_lin[0].last) n_last++;
                        void'(q_lin.pop_front());
                    end
                end
            end
            if (ovalid_g) begin
                if (q_log.size() == 0) begin
                    chk("log_extra_beat", ovalid_g, 1'b0);
                end else begin
                    chk("log_data", odata_g, q_log[0].d);
                    chk("log_last", olast_g, q_log[0].last);
                    if (iready) void'(q_log.pop_front());
                end
            end
            if (ovalid_l && iready && cons_sat) exp_sat = 1'b1;
            else if (iclr_sat) exp_sat = 1'b0;
            if (ivalid && oready_l) begin
                q_lin.push_back(model_lin(idata, int'(ishift), ilast));
                last_acc_cyc = cyc;
            end
            if (ivalid && oready_g) q_log.push_back(model_log(idata, ilast));
        end
    end

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge that accepts the beat.
    task automatic send(input logic [63:0] d, input logic [3:0] sh, input logic lst);
        int n;
        n = 0;
        ivalid = 1'b1; idata = d; ishift = sh; ilast = lst;
        @(negedge iclk);
        while (!oready_l && n < 100) begin
            @(negedge iclk);
            n++;
        end
        if (!oready_l) chk("send_timeout", oready_l, 1'b1);
        tick();
        ivalid = 1'b0;
    endtask

    task automatic wait_out(input string tag, output int lat);
        int n;
        n = 0;
        @(negedge iclk);
        while (!ovalid_l && n < 20) begin
            @(negedge iclk);
            n++;
        end
        if (!ovalid_l) chk({tag, "_timeout"}, ovalid_l, 1'b1);
        lat = cyc - last_acc_cyc;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge iclk);
        while ((q_lin.size() != 0 || q_log.size() != 0 || ovalid_l) && n < 60) begin
            @(negedge iclk);
            n++;
        end
        if (q_lin.size() != 0) chk("drain_timeout", q_lin.size(), 0);
        tick();
    endtask

    function automatic logic [63:0] rand_beat();
        logic [63:0] d;
        for (int k = 0; k < 4; k++) d[k*16 +: 16] = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
        return d;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat, base_c, base_l;
        logic rnd_on;
        irst_n = 1'b0; ivalid = 1'b0; idata = '0; ishift = '0;
        ilast = 1'b0; iready = 1'b1; iclr_sat = 1'b0;
        #2;
        chk("reset_ovalid", ovalid_l, 1'b0);
        chk("reset_odata", odata_l, 32'h0);
        chk("reset_olast", olast_l, 1'b0);
        chk("reset_osat", osat_l, 1'b0);
        chk("reset_log_odata", odata_g, 32'h0);
        repeat (2) @(posedge iclk);
        #1 irst_n = 1'b1;
        tick();

        send(64'h0180, 4'd8, 1'b0);
        wait_out("t1", lat);
        chk("t1_latency", lat, 2);
        chk("t1_odata", odata_l, 32'h0000_0002);
        chk("t1_osat", osat_l, 1'b0);
        drain();

        send(64'h0000_0000_FFFF_0000, 4'd7, 1'b0);
        wait_out("t2", lat);
        chk("t2_odata", odata_l, 32'h0000_FF00);
        drain();
        chk("t2_osat_set", osat_l, 1'b1);
        iclr_sat = 1'b1;
        tick();
        iclr_sat = 1'b0;
        @(negedge iclk);
        chk("t2_osat_clr", osat_l, 1'b0);
        tick();
        send(64'h00FF, 4'd0, 1'b0);
        drain();
        chk("t2_ff_nosat", osat_l, 1'b0);
        send(64'h0100, 4'd0, 1'b0);
        drain();
        chk("t2_100_sat", osat_l, 1'b1);

        send({16'h0123, 16'h0010, 16'h000F, 16'h0009}, 4'd0, 1'b0);
        wait_out("log_a", lat);
        chk("log_a_valid", ovalid_g, 1'b1);
        chk("log_a_odata", odata_g, 32'h5210_0F09);
        drain();
        send(64'h0000_0000_0000_FFFF, 4'd0, 1'b0);
        wait_out("log_b", lat);
        chk("log_b_odata", odata_g, 32'h0000_00CF);
        drain();

        send(64'h0400, 4'd2, 1'b0);
        send(64'h0400, 4'd4, 1'b0);
        drain();

        bp_on = 1'b1; bp_drop = 1'b0;
        base_c = n_cons; base_l = n_last;
        fork
            begin
                for (int i = 0; i < 8; i++) send(rand_beat(), 4'($urandom_range(0, 15)), i == 7);
            end
            begin
                tick(); tick();
                iready = 1'b0;
                tick(); tick(); tick();
                iready = 1'b1;
            end
        join
        drain();
        bp_on = 1'b0;
        chk("bp_oready_drop", bp_drop, 1'b1);
        chk("bp_beat_count", n_cons - base_c, 8);
        chk("bp_last_count", n_last - base_l, 1);

        send(64'h0400, 4'd2, 1'b0);
        send(64'h1234, 4'd3, 1'b0);
        chk("rst_inflight", ovalid_l, 1'b1);
        chk("rst_pre_osat", osat_l, 1'b1);
        irst_n = 1'b0;
        #1;
        chk("rst_mid_ovalid", ovalid_l, 1'b0);
        chk("rst_mid_odata", odata_l, 32'h0);
        chk("rst_mid_osat", osat_l, 1'b0);
        chk("rst_mid_log_ovalid", ovalid_g, 1'b0);
        tick();
        irst_n = 1'b1;
        tick();
        send(64'h0000_0000_0000_0150, 4'd4, 1'b1);
        wait_out("rst_post", lat);
        chk("rst_post_latency", lat, 2);
        chk("rst_post_odata", odata_l, 32'h0000_0015);
        drain();

        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    iclr_sat = ($urandom_range(0, 15) == 0);
                    repeat ($urandom_range(0, 2)) tick();
                    send(rand_beat(), 4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
                end
                iclr_sat = 1'b0;
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    tick();
                    if (rnd_on) iready = ($urandom_range(0, 3) != 0);
                end
                iready = 1'b1;
            end
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/requant_pipe.md
Name: requant_pipe

Overview:
- Multi-channel, pipelined requantiser: narrows pCH unsigned accumulator lanes of pIN_W bits to pOUT_W bits each.
- Modes: linear (runtime right shift, round-half-up, saturate) or logarithmic (leading-one segment/mantissa compression).
- Sits between the conv accumulator output and the activation/feature-map writer.
- Valid/ready streaming with full backpressure; replaces the single-lane, fixed-width, unhandshaked 16-to-8 converter.

Parameters:
- pIN_W, 16, input lane width (unsigned).
- pOUT_W, 8, output lane width.
- pCH, 4, lanes per beat.
- pMODE, "lin", "lin" or "log"; any other value is an elaboration error.
- pEXP_W, 4, log-mode segment field width; mantissa width M = pOUT_W - pEXP_W.
- Elaboration check (log mode): pIN_W - M <= 2^pEXP_W - 1 and M >= 1.

Ports:
- iclk  in  1  clock
- irst_n  in  1  asynchronous active-low reset
- ivalid  in  1  input beat valid
- oready  out  1  block can accept an input beat
- idata  in  pCH*pIN_W  packed lanes, lane k at [k*pIN_W +: pIN_W]
- ishift  in  $clog2(pIN_W)  lin-mode right shift, sampled with each beat; ignored in log mode
- ilast  in  1  sideband, delivered with its beat
- ovalid  out  1  output beat valid
- iready  in  1  downstream accepts the output beat
- odata  out  pCH*pOUT_W  packed results, same lane order as idata
- olast  out  1  ilast of the beat on odata
- osat  out  1  sticky: set when any lane saturated on an accepted output beat
- iclr_sat  in  1  synchronous clear of osat; set wins if both occur in the same cycle

Behaviour:
- Reset (async assert, sync deassert upstream): both stage valids = 0, ovalid = 0, odata = 0, olast = 0, osat = 0. Any beats in flight are discarded.
- Pipeline: 2 register stages, latency 2 cycles from input handshake to ovalid, throughput 1 beat/cycle.
- Stage advance rules:
  - adv2 = !v2 | iready
  - adv1 = !v1 | adv2
  - oready = adv1 (combinational through the ready chain, no other logic)
- Input accepted when ivalid & oready. Output consumed when ovalid & iready.
- While ovalid=1 and iready=0, odata/olast are held stable.
- No beat is dropped, duplicated or reordered.
- Each beat carries its own ishift and ilast through both stages, so changing ishift mid-stream affects only later beats.
- Lin mode, per lane, input v:
  - stage 1: s = v + (ishift>0 ? 2^(ishift-1) : 0), computed at pIN_W+1 bits, no overflow.
  - stage 2: r = s >> ishift; if r > 2^pOUT_W - 1, output all-ones and flag saturation, else output r[pOUT_W-1:0].
- Log mode, per lane, input v:
  - stage 1: leading-one index p (priority encode) and registered copy of v.
  - stage 2: if v < 2^M, output v (segment 0).
  - otherwise seg = p - M + 1, mant = v[p-1 -: M], output {seg[pEXP_W-1:0], mant}.
  - Mapping is monotonic non-decreasing; log mode never saturates.
- osat:
  - set when an output beat is consumed and any lane saturated;
  - cleared only by iclr_sat or reset;
  - flagged per beat, so a held, unconsumed beat does not set it.
- Simultaneous accept and consume with a full pipe: both stages advance in the same cycle, and oready stays 1 while iready=1.

Decomposition:
- Package requant_pkg:
  - mode enum/string constants;
  - localparam helpers: M, shift width;
  - functions lead_one_idx() and sat_u().
- Sub-module requant_lane: one lane's stage-1 and stage-2 datapath registers, with enables from shared control.
- Top module: handshake/valid control, sideband (ishift, ilast) pipeline, osat, and a generate loop over pCH lanes.

Test Plan:
- Lin, ishift=8, lane0=0x0180, others 0 -> lane0=0x02, others 0x00, ovalid exactly 2 cycles after accept, osat=0.
- Lin, ishift=7, lane1=0xFFFF -> lane1=0xFF, osat=1; then iclr_sat pulse -> osat=0. Also ishift=0, 0x00FF -> 0xFF with osat unchanged, and 0x0100 -> 0xFF with osat=1.
- Log (defaults, M=4) -> expected outputs:
  - 0x0009 -> 0x09
  - 0x000F -> 0x0F
  - 0x0010 -> 0x10
  - 0x0123 -> 0x52
  - 0xFFFF -> 0xCF
  - 0x0000 -> 0x00
- Backpressure: stream 8 beats (ilast on beat 8) with iready low for cycles 3-5 -> oready drops once both stages are full; odata held stable; all 8 beats arrive in order; olast only on beat 8.
- Per-beat shift: back-to-back beats of 0x0400 with ishift=2 then ishift=4 -> outputs 0xFF (sat) then 0x40.
- Reset mid-stream: assert irst_n=0 with 2 beats in flight -> ovalid=0, odata=0, osat=0 immediately; after release, the first new beat emerges with latency 2 and no stale beats.
